md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit sitting in the EX stage beside the ALU, driven by the decoder's `start`/`op`/`HI_En`/`LO_En` outputs. It holds the HI and LO registers, runs multi-cycle signed/unsigned multiply, divide and multiply-accumulate/subtract operations with configurable latency, and raises `stall_req` so the hazard unit can hold any mult/div/mfhi/mflo/mthi/mtlo instruction in D while the unit is occupied.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 2)
- `MULT_CYCLES`, 5, busy cycles for ops 0,1,4–7 (≥ 1)
- `DIV_CYCLES`, 10, busy cycles for ops 2,3 (≥ 1)

- `clk` input 1 rising-edge clock
- `reset` input 1 asynchronous, active-high; clears all state
- `start` input 1 begin operation `op` on `A`,`B` this cycle
- `op` input 3 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu
- `A` input WIDTH rs operand / mthi-mtlo data
- `B` input WIDTH rt operand
- `HI_En` input 1 write `A` into HI (mthi)
- `LO_En` input 1 write `A` into LO (mtlo)
- `busy` output 1 operation in progress
- `stall_req` output 1 combinational `start | busy`
- `HI` output WIDTH HI register
- `LO` output WIDTH LO register

## Operation
- States: IDLE, RUN. Counter width covers max(MULT_CYCLES, DIV_CYCLES).
- IDLE + `start`: latch `A`, `B`, `op`; load counter with N (MULT_CYCLES or DIV_CYCLES by op); go RUN.
- RUN: decrement counter each edge; on the edge where it would reach 0, write result to HI/LO, go IDLE.
- `start`, `HI_En`, `LO_En` are ignored while `busy`=1 (hazard unit guarantees they are not issued; unit must not corrupt state if they are).
- IDLE, no `start`: `HI_En` writes HI←A, `LO_En` writes LO←A; both may assert together.
- Same-cycle `start` with `HI_En`/`LO_En`: `start` wins, writes ignored.
- Arithmetic (operands as latched):
  - mult/multu: {HI,LO} ← signed/unsigned A×B, full 2·WIDTH product.
  - madd/maddu: {HI,LO} ← {HI,LO} + product, mod 2^(2·WIDTH); msub/msubu: {HI,LO} − product. HI/LO values used are those at completion (unchanged since start).
  - div/divu: LO ← quotient truncated toward zero, HI ← remainder with sign of dividend.
  - Signed −2^(WIDTH−1) ÷ −1: LO ← −2^(WIDTH−1), HI ← 0.
  - Divide by zero: HI, LO unchanged; full DIV_CYCLES busy still spent.
- Reset (any time, including RUN): state IDLE, counter 0, HI=LO=0, busy=0; pending op discarded.

## Timing
- Reset values: `busy`=0, `stall_req`=`start`, `HI`=0, `LO`=0.
- `start` sampled at edge E0 → `busy`=1 after E0 for exactly N cycles → at edge E0+N, HI/LO hold result and `busy`=0.
- `stall_req` rises combinationally in the `start` cycle; falls in the cycle after E0+N (absent a new `start`).
- Back-to-back: new `start` accepted in the first cycle `busy`=0 (edge E0+N+1 earliest).
- mthi/mtlo: visible on `HI`/`LO` one edge after `HI_En`/`LO_En` sampled.
- `A`/`B` may change freely after E0 without affecting result.

## Test plan
- Reset, then mult op=0 A=0xFFFFFFFE (−2) B=3 → busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x2, LO=0xFFFFFFFA.
- div op=2 A=−7 B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=0 with HI=0x11, LO=0x22 preloaded → unchanged after 10 cycles.
- mthi 0x1, mtlo 0xFFFFFFFF, then maddu A=1 B=1 → HI=0x2, LO=0; then msub A=2 B=1 → HI=0x1, LO=0xFFFFFFFE.
- Start div, assert HI_En/LO_En/start with other values mid-RUN → ignored; final HI/LO equal div result only.
- Assert reset 3 cycles into a div → busy, HI, LO immediately 0; no later write occurs.
- WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3: mult A=0x80 B=0xFF → busy 1 cycle, HI=0x00, LO=0x80; div 0x80÷0xFF → LO=0x80, HI=0x00.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the HI/LO pair.
// Handshake: `start` is sampled only when the unit is idle. It then runs for
// exactly N cycles with `busy` high and commits HI/LO on the edge that drops
// `busy`. `stall_req` = start | busy, so the decoder holds any mult/div/mt/mf
// instruction in D until the result is committed. start/HI_En/LO_En arriving
// while busy are dropped without touching any state.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HI_En,
  input  logic             LO_En,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                done;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [2:0]          op_q;

  // Datapath signals
  logic                sgn;
  logic                is_div_q;
  logic [2*WIDTH-1:0]  a_ext, b_ext, prod, acc, res;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic                wr_res;
  logic                mt_ok;

  assign busy      = (state == RUN);
  assign stall_req = start | busy;

  // FSM state and cycle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: load N on start, count down in RUN, finish when reaching 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          cnt_nx   = (op[2:1] == 2'b01) ? DIV_N : MULT_N;
        end
      end
      RUN: begin
        if (cnt == ONE) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done     = 1'b1;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Result datapath on latched operands; even opcodes are the signed variants
  always_comb begin
    sgn      = ~op_q[0];
    is_div_q = (op_q[2:1] == 2'b01);
    a_ext    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Low 2*WIDTH bits of the extended product are the exact signed/unsigned product
    prod     = a_ext * b_ext;
    acc      = {HI, LO};
    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. MIN / -1 wraps back to MIN naturally.
    a_neg    = sgn & a_q[WIDTH-1];
    b_neg    = sgn & b_q[WIDTH-1];
    a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
    b_safe   = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem      = a_neg ? (~r_mag + 1'b1) : r_mag;
    case (op_q)
      3'd0, 3'd1: res = prod;
      3'd2, 3'd3: res = {rem, quot};
      3'd4, 3'd5: res = acc + prod;
      default:    res = acc - prod;
    endcase
    // Divide by zero leaves HI/LO untouched
    wr_res   = done & ~(is_div_q & (b_q == '0));
    mt_ok    = (state == IDLE) & ~start;
  end

  // Operand latch and HI/LO register updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
      if (wr_res) begin
        HI <= res[2*WIDTH-1:WIDTH];
        LO <= res[WIDTH-1:0];
      end else if (mt_ok) begin
        if (HI_En) HI <= A;
        if (LO_En) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a 32-bit instance with default latencies and an
// 8-bit instance with short latencies, both checked against a reference model
// via an expected-result queue.
module tb_md_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] A = '0, B = '0;
  logic        HI_En = 1'b0, LO_En = 1'b0;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .HI_En(HI_En), .LO_En(LO_En), .busy(busy), .stall_req(stall_req),
    .HI(HI), .LO(LO)
  );

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       he8 = 1'b0, le8 = 1'b0;
  logic       busy8, stall8;
  logic [7:0] hi8, lo8;

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
    .HI_En(he8), .LO_En(le8), .busy(busy8), .stall_req(stall8),
    .HI(hi8), .LO(lo8)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] hl_m = '0;
  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for the 32-bit instance
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    int          sa, sb, q, r;
    longint      ps;
    logic [63:0] pu, e;
    sa = a;
    sb = b;
    ps = longint'(sa) * longint'(sb);
    pu = {32'b0, a} * {32'b0, b};
    e  = hl;
    case (o)
      3'd0: e = ps;
      3'd1: e = pu;
      3'd2: begin
        if (b == 32'd0) e = hl;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          e = {r, q};
        end
      end
      3'd3: e = (b == 32'd0) ? hl : {a % b, a / b};
      3'd4: e = hl + ps;
      3'd5: e = hl + pu;
      3'd6: e = hl - ps;
      default: e = hl - pu;
    endcase
    return e;
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mt);
    logic [63:0] e;
    e = model(o, a, b, hl_m);
    hl_m = e;
    exp_q.push_back(e);
    start = 1'b1; op = o; A = a; B = b; HI_En = mt; LO_En = mt;
    #1 check("stall_on_start", {63'b0, stall_req}, 64'd1);
    @(negedge clk);
    start = 1'b0; HI_En = 1'b0; LO_En = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  task automatic finish_op(input int n, input int pre, input string tag);
    int cyc;
    logic [63:0] e;
    cyc = pre;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    if (exp_q.size() == 0) check({tag, "_queue"}, 64'd0, 64'd1);
    else begin
      e = exp_q.pop_front();
      check({tag, "_hilo"}, {HI, LO}, e);
    end
    check({tag, "_stall_off"}, {63'b0, stall_req}, 64'd0);
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] v);
    HI_En = h; LO_En = l; A = v;
    @(negedge clk);
    HI_En = 1'b0; LO_En = 1'b0;
    if (h) hl_m[63:32] = v;
    if (l) hl_m[31:0] = v;
    check("mt_write", {HI, LO}, hl_m);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input int n, input logic [15:0] e16, input string tag);
    int cyc;
    logic [63:0] e;
    exp_q.push_back({48'b0, e16});
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    #1 check({tag, "_stall_on"}, {63'b0, stall8}, 64'd1);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    e = exp_q.pop_front();
    check({tag, "_hilo"}, {48'b0, hi8, lo8}, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [2:0] ro;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_stall", {63'b0, stall_req}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    // mult -2*3, then multu same operands with mthi/mtlo in the start cycle (start wins)
    start_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    finish_op(5, 0, "mult");
    check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    start_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    finish_op(5, 0, "multu");
    check("multu_const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

    // div -7/2
    start_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    finish_op(10, 0, "div");
    check("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divu by zero leaves preloaded HI/LO
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    start_op(3'd3, 32'd7, 32'd0, 1'b0);
    finish_op(10, 0, "divu_zero");
    check("divu_zero_const", {HI, LO}, 64'h0000_0011_0000_0022);

    // maddu / msub accumulation
    mt(1'b1, 1'b0, 32'h1);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    start_op(3'd5, 32'd1, 32'd1, 1'b0);
    finish_op(5, 0, "maddu");
    check("maddu_const", {HI, LO}, 64'h0000_0002_0000_0000);
    start_op(3'd6, 32'd2, 32'd1, 1'b0);
    finish_op(5, 0, "msub");
    check("msub_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

    // signed overflow MIN / -1
    start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    finish_op(10, 0, "div_ovf");

    // writes and a new start issued mid-RUN must be ignored
    start_op(3'd2, 32'd100, 32'd7, 1'b0);
    start = 1'b1; op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h1234; HI_En = 1'b1; LO_En = 1'b1;
    #1 check("stall_busy", {63'b0, stall_req}, 64'd1);
    @(negedge clk);
    start = 1'b0; HI_En = 1'b0; LO_En = 1'b0;
    finish_op(10, 1, "div_interfere");

    // mthi and mtlo in the same cycle
    mt(1'b1, 1'b1, 32'hCAFE_0001);

    // random back-to-back ops
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      n  = (ro[2:1] == 2'b01) ? 10 : 5;
      start_op(ro, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom, 1'b0);
      finish_op(n, 0, "rand");
    end

    // reset three cycles into a divide
    start_op(3'd2, 32'd50, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    void'(exp_q.pop_back());
    hl_m = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_after_busy", {63'b0, busy}, 64'd0);
    check("rst_after_hilo", {HI, LO}, 64'd0);

    // 8-bit instance with short latencies
    run8(3'd0, 8'h80, 8'hFF, 1, 16'h0080, "w8_mult");
    run8(3'd2, 8'h80, 8'hFF, 3, 16'h0080, "w8_div");
    run8(3'd1, 8'h80, 8'hFF, 1, 16'h7F80, "w8_multu");
    run8(3'd2, 8'hF9, 8'h02, 3, 16'hFFFD, "w8_div_neg");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
